// File: rtl/frame_mem_pkg.sv
// Shared defaults and enums for the framebuffer read arbiter.
package frame_mem_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 3;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_DET_NORM,
        ST_DET_FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_DET
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating 4-bit count of consecutive detector denials with a limit flag.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic inc,
    input  logic clear,
    output logic limit_reached
);

    logic [3:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != 4'hF) begin
            count <= count + 4'd1;
        end
    end

    assign limit_reached = (count >= 4'(LIMIT));

endmodule

// File: rtl/frame_mem_arbiter.sv
// Two-port framebuffer read arbiter: display has priority, detector is forced in after
// STARVE_LIMIT consecutive denials. Optional stats counters under FRAME_ARB_STATS_EN.
//
// state        | meaning
// ST_IDLE      | no framebuffer access issued last cycle
// ST_VID       | display read in flight
// ST_DET_NORM  | detector read in flight, won on default priority
// ST_DET_FORCE | detector read in flight, won by starvation override
module frame_mem_arbiter
    import frame_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_grant,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              det_req,
    input  logic [ADDR_W-1:0] det_addr,
    output logic              det_grant,
    output logic              det_valid,
    output logic [DATA_W-1:0] det_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [15:0]       det_grant_cnt,
    output logic [15:0]       det_force_cnt
`endif
);

    arb_state_t        state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] vid_hold, det_hold;
    logic              limit_reached;
    logic              force_det;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .Clock        (Clock),
        .Reset        (Reset),
        .inc          (det_req & ~det_grant),
        .clear        (~det_req | det_grant),
        .limit_reached(limit_reached)
    );

    // Grants are gated by Reset so nothing reaches the framebuffer while held in reset.
    assign force_det = det_req & limit_reached;
    assign det_grant = Reset & det_req & (force_det | ~vid_req);
    assign vid_grant = Reset & vid_req & ~force_det;
    assign mem_en    = vid_grant | det_grant;
    assign mem_addr  = det_grant ? det_addr : (vid_grant ? vid_addr : addr_q);

    always_comb begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
        if (det_grant) begin
            state_nxt = force_det ? ST_DET_FORCE : ST_DET_NORM;
            owner_nxt = OWN_DET;
        end else if (vid_grant) begin
            state_nxt = ST_VID;
            owner_nxt = OWN_VID;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            addr_q   <= '0;
            vid_hold <= '0;
            det_hold <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            addr_q   <= mem_addr;
            vid_hold <= vid_data;
            det_hold <= det_data;
        end
    end

    // Read data arrives in the valid cycle, so it is steered straight through and then held.
    assign vid_valid = (state == ST_VID);
    assign det_valid = (state == ST_DET_NORM) || (state == ST_DET_FORCE);
    assign vid_data  = (owner == OWN_VID) ? mem_rdata : vid_hold;
    assign det_data  = (owner == OWN_DET) ? mem_rdata : det_hold;

`ifdef FRAME_ARB_STATS_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            det_grant_cnt <= '0;
            det_force_cnt <= '0;
        end else begin
            if (det_grant && det_grant_cnt != 16'hFFFF)
                det_grant_cnt <= det_grant_cnt + 16'd1;
            if (state_nxt == ST_DET_FORCE && det_force_cnt != 16'hFFFF)
                det_force_cnt <= det_force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/frame_mem_arbiter.md
FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, framebuffer address width {x[15:8], y[7:0]}.
REQ-002 SHALL have parameter DATA_W, default 3, pixel colour width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive detector denials before forced detector grant; legal range 1..15.
REQ-004 Ports, clock and reset first: one clock, reset asynchronous active-low.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- vid_req  in  1  display scanout read request.
- vid_addr  in  ADDR_W  display read address.
- vid_grant  out  1  display access issued this cycle.
- vid_valid  out  1  vid_data valid, one-cycle pulse.
- vid_data  out  DATA_W  display read data.
- det_req  in  1  collision-detector read request.
- det_addr  in  ADDR_W  detector read address.
- det_grant  out  1  detector access issued this cycle.
- det_valid  out  1  det_data valid, one-cycle pulse.
- det_data  out  DATA_W  detector read data.
- mem_en  out  1  framebuffer read enable.
- mem_addr  out  ADDR_W  framebuffer read address.
- mem_rdata  in  DATA_W  framebuffer data, one cycle after mem_en.

Function
REQ-005 SHALL issue at most one framebuffer read per cycle; mem_en equals vid_grant OR det_grant.
REQ-006 Grants SHALL be combinational from the current requests and the registered state; mem_addr SHALL be the granted requester's address, else hold its last value.
REQ-007 Default priority SHALL go to the display: both requesting grants vid, unless forced (REQ-009).
REQ-008 A 4-bit starve counter SHALL increment each cycle det_req=1 and det_grant=0; it SHALL clear when det_grant=1 or det_req=0.
REQ-009 When starve counter >= STARVE_LIMIT and det_req=1, det SHALL be granted regardless of vid_req; the display is denied that cycle.
REQ-010 Requester handshake: req and addr SHALL be held stable until grant; req deasserted before grant SHALL cause no access and no valid.
REQ-011 Read latency SHALL be exactly 1 cycle: grant in cycle N -> <x>_valid=1 and <x>_data=mem_rdata in cycle N+1.
REQ-012 An owner tag register SHALL record the grantee of cycle N for steering the N+1 data; back-to-back grants SHALL sustain one read per cycle.
REQ-013 <x>_data SHALL be registered outputs that hold their last value when <x>_valid=0.
REQ-014 FSM states: IDLE (no access), VID (display access), DET_NORM (detector, default priority), DET_FORCE (detector, starvation override); next state chosen each cycle from requests and starve counter; any state reachable from any state.
REQ-015 Starve counter SHALL saturate at 15.

Reset
REQ-016 Reset=0 SHALL asynchronously force state IDLE, owner tag none, starve counter 0, vid_valid=0, det_valid=0, vid_data=0, det_data=0, mem_addr=0.
REQ-017 Reset asserted while a read is in flight SHALL discard it: no valid pulse after reset release.
REQ-018 While Reset=0, grants and mem_en SHALL be 0.

Configuration
REQ-019 Macro FRAME_ARB_STATS_EN defined: adds outputs det_grant_cnt (16 bits) and det_force_cnt (16 bits), saturating counts of detector grants and DET_FORCE cycles, reset to 0.
REQ-020 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-021 Package frame_mem_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state enum, and the owner-tag enum (NONE, VID, DET).
REQ-022 Sub-module arb_starve_counter (saturating 4-bit counter, inc/clear inputs, limit-reached output) SHALL be used; all else in one module.

Verification
REQ-023 vid_req=1 addr 0x1020, det_req=0 -> vid_grant same cycle, mem_addr=0x1020; mem_rdata=3'b101 -> vid_valid=1, vid_data=3'b101 next cycle.
REQ-024 vid_req and det_req held 1 continuously, STARVE_LIMIT=4 -> vid granted 4 cycles, det granted 5th (DET_FORCE), pattern repeats every 5 cycles.
REQ-025 Back-to-back: det N addr 0x4130, vid N+1 addr 0x0000 -> det_valid N+1, vid_valid N+2, data steered correctly, no gap.
REQ-026 det_req raised 2 cycles then dropped while vid busy -> no det_grant, no det_valid, starve counter back to 0.
REQ-027 Reset=0 asserted asynchronously in the cycle after a vid grant -> vid_valid stays 0, all outputs at reset values immediately.
REQ-028 With FRAME_ARB_STATS_EN, scenario REQ-024 for 20 cycles -> det_grant_cnt=4, det_force_cnt=4.
